// File: rtl/reorder_buffer_pkg.sv
// Shared widths, types and helpers for the reorder buffer and its interface.
package reorder_buffer_pkg;

  localparam int unsigned ROB_SZ     = 16;
  localparam int unsigned ROB_ID_WID = 4;
  localparam int unsigned DATA_WID   = 32;
  localparam int unsigned REG_ID_WID = 5;
  localparam int unsigned ADDR_WID   = 32;

  typedef logic [ROB_ID_WID-1:0] rob_id_t;
  typedef logic [ROB_ID_WID:0]   rob_cnt_t;
  typedef logic [DATA_WID-1:0]   data_t;
  typedef logic [REG_ID_WID-1:0] reg_id_t;
  typedef logic [ADDR_WID-1:0]   addr_t;

  function automatic logic is_mispredict(logic is_branch, logic pred_jump, logic jump);
    return is_branch && (jump != pred_jump);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, writeback, operand query and commit/rollback signals of the reorder buffer.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic    rdy;
  logic    issue_valid;
  logic    issue_has_rd;
  reg_id_t issue_rd;
  logic    issue_is_branch;
  logic    issue_pred_jump;
  addr_t   issue_pc_alt;
  logic    full;
  rob_id_t alloc_rob_id;
  logic    wb_valid;
  rob_id_t wb_rob_id;
  data_t   wb_data;
  logic    wb_jump;
  rob_id_t q1_rob_id;
  rob_id_t q2_rob_id;
  logic    q1_ready;
  logic    q2_ready;
  data_t   q1_data;
  data_t   q2_data;
  logic    is_commit;
  reg_id_t commit_rd;
  data_t   commit_data;
  rob_id_t commit_rob_id;
  logic    rollback;
  addr_t   rollback_pc;

  modport master (
    output rdy, issue_valid, issue_has_rd, issue_rd, issue_is_branch, issue_pred_jump,
           issue_pc_alt, wb_valid, wb_rob_id, wb_data, wb_jump, q1_rob_id, q2_rob_id,
    input  full, alloc_rob_id, q1_ready, q2_ready, q1_data, q2_data, is_commit, commit_rd,
           commit_data, commit_rob_id, rollback, rollback_pc
  );

  modport slave (
    input  rdy, issue_valid, issue_has_rd, issue_rd, issue_is_branch, issue_pred_jump,
           issue_pc_alt, wb_valid, wb_rob_id, wb_data, wb_jump, q1_rob_id, q2_rob_id,
    output full, alloc_rob_id, q1_ready, q2_ready, q1_data, q2_data, is_commit, commit_rd,
           commit_data, commit_rob_id, rollback, rollback_pc
  );

endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates on issue, collects CDB results, commits from the head
// and flushes everything when the head branch turns out mispredicted.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  reorder_buffer_if.slave bus
);

  localparam rob_cnt_t CntFull = rob_cnt_t'(ROB_SZ);

  rob_id_t  head_q, head_d, tail_q, tail_d;
  rob_cnt_t count_q, count_d;

  logic [ROB_SZ-1:0] valid_q, valid_d, ready_q, ready_d, has_rd_q, has_rd_d;
  logic [ROB_SZ-1:0] is_branch_q, is_branch_d, pred_jump_q, pred_jump_d, jump_q, jump_d;
  reg_id_t rd_q     [ROB_SZ];
  reg_id_t rd_d     [ROB_SZ];
  addr_t   pc_alt_q [ROB_SZ];
  addr_t   pc_alt_d [ROB_SZ];
  data_t   data_q   [ROB_SZ];
  data_t   data_d   [ROB_SZ];

  logic    is_commit_q, is_commit_d, rollback_q, rollback_d;
  reg_id_t commit_rd_q, commit_rd_d;
  data_t   commit_data_q, commit_data_d;
  rob_id_t commit_rob_id_q, commit_rob_id_d;
  addr_t   rollback_pc_q, rollback_pc_d;

  logic full, do_issue, do_commit;
  logic q1_ready, q2_ready;
  data_t q1_data, q2_data;

  assign full      = (count_q == CntFull);
  // Commit looks at registered state only, so a result retires no earlier than the next cycle.
  assign do_commit = valid_q[head_q] && ready_q[head_q];
  assign do_issue  = bus.issue_valid && !full;

  always_comb begin
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    valid_d         = valid_q;
    ready_d         = ready_q;
    has_rd_d        = has_rd_q;
    is_branch_d     = is_branch_q;
    pred_jump_d     = pred_jump_q;
    jump_d          = jump_q;
    rd_d            = rd_q;
    pc_alt_d        = pc_alt_q;
    data_d          = data_q;
    is_commit_d     = 1'b0;
    rollback_d      = 1'b0;
    commit_rd_d     = commit_rd_q;
    commit_data_d   = commit_data_q;
    commit_rob_id_d = commit_rob_id_q;
    rollback_pc_d   = rollback_pc_q;

    if (bus.rdy) begin
      if (bus.wb_valid && valid_q[bus.wb_rob_id]) begin
        ready_d[bus.wb_rob_id] = 1'b1;
        data_d[bus.wb_rob_id]  = bus.wb_data;
        jump_d[bus.wb_rob_id]  = bus.wb_jump;
      end

      if (do_issue) begin
        valid_d[tail_q]     = 1'b1;
        ready_d[tail_q]     = 1'b0;
        has_rd_d[tail_q]    = bus.issue_has_rd;
        rd_d[tail_q]        = bus.issue_rd;
        is_branch_d[tail_q] = bus.issue_is_branch;
        pred_jump_d[tail_q] = bus.issue_pred_jump;
        pc_alt_d[tail_q]    = bus.issue_pc_alt;
        tail_d              = tail_q + rob_id_t'(1);
      end

      if (do_commit) begin
        is_commit_d     = has_rd_q[head_q];
        commit_rd_d     = rd_q[head_q];
        commit_data_d   = data_q[head_q];
        commit_rob_id_d = head_q;
        valid_d[head_q] = 1'b0;
        head_d          = head_q + rob_id_t'(1);
      end

      if (do_issue && !do_commit) begin
        count_d = count_q + rob_cnt_t'(1);
      end else if (!do_issue && do_commit) begin
        count_d = count_q - rob_cnt_t'(1);
      end

      // Flush wins over any same-cycle allocation; the branch's own commit strobe stands.
      if (do_commit && is_mispredict(is_branch_q[head_q], pred_jump_q[head_q], jump_q[head_q]))
      begin
        rollback_d    = 1'b1;
        rollback_pc_d = pc_alt_q[head_q];
        valid_d       = '0;
        head_d        = '0;
        tail_d        = '0;
        count_d       = '0;
      end
    end
  end

  always_comb begin
    q1_ready = 1'b0;
    q1_data  = '0;
    if (bus.wb_valid && bus.wb_rob_id == bus.q1_rob_id && valid_q[bus.q1_rob_id]) begin
      q1_ready = 1'b1;
      q1_data  = bus.wb_data;
    end else if (valid_q[bus.q1_rob_id] && ready_q[bus.q1_rob_id]) begin
      q1_ready = 1'b1;
      q1_data  = data_q[bus.q1_rob_id];
    end
  end

  always_comb begin
    q2_ready = 1'b0;
    q2_data  = '0;
    if (bus.wb_valid && bus.wb_rob_id == bus.q2_rob_id && valid_q[bus.q2_rob_id]) begin
      q2_ready = 1'b1;
      q2_data  = bus.wb_data;
    end else if (valid_q[bus.q2_rob_id] && ready_q[bus.q2_rob_id]) begin
      q2_ready = 1'b1;
      q2_data  = data_q[bus.q2_rob_id];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      valid_q         <= '0;
      ready_q         <= '0;
      has_rd_q        <= '0;
      is_branch_q     <= '0;
      pred_jump_q     <= '0;
      jump_q          <= '0;
      for (int i = 0; i < ROB_SZ; i++) begin
        rd_q[i]     <= '0;
        pc_alt_q[i] <= '0;
        data_q[i]   <= '0;
      end
      is_commit_q     <= 1'b0;
      commit_rd_q     <= '0;
      commit_data_q   <= '0;
      commit_rob_id_q <= '0;
      rollback_q      <= 1'b0;
      rollback_pc_q   <= '0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      valid_q         <= valid_d;
      ready_q         <= ready_d;
      has_rd_q        <= has_rd_d;
      is_branch_q     <= is_branch_d;
      pred_jump_q     <= pred_jump_d;
      jump_q          <= jump_d;
      rd_q            <= rd_d;
      pc_alt_q        <= pc_alt_d;
      data_q          <= data_d;
      is_commit_q     <= is_commit_d;
      commit_rd_q     <= commit_rd_d;
      commit_data_q   <= commit_data_d;
      commit_rob_id_q <= commit_rob_id_d;
      rollback_q      <= rollback_d;
      rollback_pc_q   <= rollback_pc_d;
    end
  end

  assign bus.full          = full;
  assign bus.alloc_rob_id  = tail_q;
  assign bus.q1_ready      = q1_ready;
  assign bus.q1_data       = q1_data;
  assign bus.q2_ready      = q2_ready;
  assign bus.q2_data       = q2_data;
  assign bus.is_commit     = is_commit_q;
  assign bus.commit_rd     = commit_rd_q;
  assign bus.commit_data   = commit_data_q;
  assign bus.commit_rob_id = commit_rob_id_q;
  assign bus.rollback      = rollback_q;
  assign bus.rollback_pc   = rollback_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: expected commit/rollback events go into a scoreboard
// queue and a negedge monitor pops them as the DUT strobes.
module tb_reorder_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reorder_buffer_if bus ();

  reorder_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        is_commit;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [3:0]  id;
    logic        rollback;
    logic [31:0] pc;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  vectors = 0;
  int  miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic c, input logic [4:0] rd, input logic [31:0] d,
                      input logic [3:0] id, input logic rb, input logic [31:0] pc);
    ev_t e;
    e.is_commit = c; e.rd = rd; e.data = d; e.id = id; e.rollback = rb; e.pc = pc;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && (bus.is_commit === 1'b1 || bus.rollback === 1'b1)) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_strobe: got is_commit=%0b rollback=%0b rob_id=%0d expected none",
                 bus.is_commit, bus.rollback, bus.commit_rob_id);
      end else begin
        mon_e = exp_q.pop_front();
        check("is_commit", {63'd0, bus.is_commit}, {63'd0, mon_e.is_commit});
        check("rollback", {63'd0, bus.rollback}, {63'd0, mon_e.rollback});
        if (mon_e.rollback) begin
          check("rollback_pc", {32'd0, bus.rollback_pc}, {32'd0, mon_e.pc});
        end else begin
          check("commit_rd", {59'd0, bus.commit_rd}, {59'd0, mon_e.rd});
          check("commit_data", {32'd0, bus.commit_data}, {32'd0, mon_e.data});
          check("commit_rob_id", {60'd0, bus.commit_rob_id}, {60'd0, mon_e.id});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_valid = 0; bus.issue_has_rd = 0; bus.issue_rd = '0; bus.issue_is_branch = 0;
    bus.issue_pred_jump = 0; bus.issue_pc_alt = '0; bus.wb_valid = 0; bus.wb_rob_id = '0;
    bus.wb_data = '0; bus.wb_jump = 0; bus.q1_rob_id = '0; bus.q2_rob_id = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.rdy = 1;
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic issue(input logic has_rd, input logic [4:0] rd, input logic br,
                       input logic pred, input logic [31:0] pc, input int exp_id);
    bus.issue_valid = 1; bus.issue_has_rd = has_rd; bus.issue_rd = rd;
    bus.issue_is_branch = br; bus.issue_pred_jump = pred; bus.issue_pc_alt = pc;
    #1;
    check("alloc_rob_id", {60'd0, bus.alloc_rob_id}, 64'(exp_id));
    tick();
    bus.issue_valid = 0;
  endtask

  task automatic wb(input logic [3:0] id, input logic [31:0] d, input logic j);
    bus.wb_valid = 1; bus.wb_rob_id = id; bus.wb_data = d; bus.wb_jump = j;
    tick();
    bus.wb_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    do_reset();
    tick();
    check("rst_is_commit", {63'd0, bus.is_commit}, 64'd0);
    check("rst_rollback", {63'd0, bus.rollback}, 64'd0);
    check("rst_commit_rd", {59'd0, bus.commit_rd}, 64'd0);
    check("rst_commit_data", {32'd0, bus.commit_data}, 64'd0);
    check("rst_rollback_pc", {32'd0, bus.rollback_pc}, 64'd0);
    check("rst_full", {63'd0, bus.full}, 64'd0);
    check("rst_alloc", {60'd0, bus.alloc_rob_id}, 64'd0);

    // Single issue, writeback, commit
    do_reset();
    issue(1, 5'd5, 0, 0, 32'h0, 0);
    push(1, 5'd5, 32'h1234, 4'd0, 0, 32'h0);
    wb(4'd0, 32'h1234, 0);
    tick(); tick();
    check("t1_alloc_after", {60'd0, bus.alloc_rob_id}, 64'd1);
    check("t1_full", {63'd0, bus.full}, 64'd0);

    // Out-of-order writeback, in-order commit
    do_reset();
    issue(1, 5'd1, 0, 0, 32'h0, 0);
    issue(1, 5'd2, 0, 0, 32'h0, 1);
    wb(4'd1, 32'h22, 0);
    tick(); tick(); tick();
    bus.q1_rob_id = 4'd1;
    #1;
    check("t2_q1_ready_stored", {63'd0, bus.q1_ready}, 64'd1);
    check("t2_q1_data_stored", {32'd0, bus.q1_data}, 64'h22);
    push(1, 5'd1, 32'h11, 4'd0, 0, 32'h0);
    push(1, 5'd2, 32'h22, 4'd1, 0, 32'h0);
    wb(4'd0, 32'h11, 0);
    tick(); tick(); tick();

    // Fill to full, rejected issue, wrap
    do_reset();
    for (int i = 0; i < 16; i++) issue(1, 5'(i), 0, 0, 32'h0, i);
    check("t3_full", {63'd0, bus.full}, 64'd1);
    check("t3_alloc_wrap", {60'd0, bus.alloc_rob_id}, 64'd0);
    bus.issue_valid = 1; bus.issue_has_rd = 1; bus.issue_rd = 5'd31;
    tick();
    bus.issue_valid = 0;
    check("t3_full_after_17th", {63'd0, bus.full}, 64'd1);
    wb(4'd0, 32'hA0, 0);
    push(1, 5'd0, 32'hA0, 4'd0, 0, 32'h0);
    bus.issue_valid = 1; bus.issue_has_rd = 1; bus.issue_rd = 5'd20;
    tick();
    bus.issue_valid = 0;
    #1;
    check("t3_full_after_commit", {63'd0, bus.full}, 64'd0);
    issue(1, 5'd20, 0, 0, 32'h0, 0);
    check("t3_full_again", {63'd0, bus.full}, 64'd1);

    // Mispredicted branch at head flushes younger entries and a same-cycle issue
    do_reset();
    issue(0, 5'd0, 1, 0, 32'h100, 0);
    issue(1, 5'd7, 0, 0, 32'h0, 1);
    issue(1, 5'd8, 0, 0, 32'h0, 2);
    wb(4'd1, 32'h77, 0);
    wb(4'd0, 32'h0, 1);
    push(0, 5'd0, 32'h0, 4'd0, 1, 32'h100);
    issue(1, 5'd9, 0, 0, 32'h0, 3);
    check("t4_alloc_after_flush", {60'd0, bus.alloc_rob_id}, 64'd0);
    check("t4_full", {63'd0, bus.full}, 64'd0);
    bus.q1_rob_id = 4'd1;
    #1;
    check("t4_q1_flushed", {63'd0, bus.q1_ready}, 64'd0);
    tick();
    check("t4_rollback_pulse", {63'd0, bus.rollback}, 64'd0);
    tick(); tick();

    // Same-cycle writeback forwarding and invalid ids
    do_reset();
    for (int i = 0; i < 4; i++) issue(1, 5'd3, 0, 0, 32'h0, i);
    bus.wb_valid = 1; bus.wb_rob_id = 4'd3; bus.wb_data = 32'hAA;
    bus.q1_rob_id = 4'd3; bus.q2_rob_id = 4'd2;
    #1;
    check("t5_q1_fwd_ready", {63'd0, bus.q1_ready}, 64'd1);
    check("t5_q1_fwd_data", {32'd0, bus.q1_data}, 64'hAA);
    check("t5_q2_not_ready", {63'd0, bus.q2_ready}, 64'd0);
    bus.q2_rob_id = 4'd5;
    #1;
    check("t5_q2_invalid_ready", {63'd0, bus.q2_ready}, 64'd0);
    check("t5_q2_invalid_data", {32'd0, bus.q2_data}, 64'd0);
    tick();
    bus.wb_valid = 0;
    #1;
    check("t5_q1_stored", {32'd0, bus.q1_data}, 64'hAA);
    wb(4'd7, 32'hBB, 0);
    bus.q1_rob_id = 4'd7;
    #1;
    check("t5_wb_invalid_ignored", {63'd0, bus.q1_ready}, 64'd0);

    // rdy freeze, then mid-stream reset
    do_reset();
    issue(1, 5'd9, 0, 0, 32'h0, 0);
    wb(4'd0, 32'h99, 0);
    bus.rdy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_frozen_is_commit", {63'd0, bus.is_commit}, 64'd0);
    end
    push(1, 5'd9, 32'h99, 4'd0, 0, 32'h0);
    bus.rdy = 1;
    tick();
    check("t6_commit_rd", {59'd0, bus.commit_rd}, 64'd9);
    issue(1, 5'd10, 0, 0, 32'h0, 1);
    wb(4'd1, 32'h55, 0);
    rst_n = 0;
    tick();
    rst_n = 1;
    check("t6_rst_is_commit", {63'd0, bus.is_commit}, 64'd0);
    check("t6_rst_commit_rd", {59'd0, bus.commit_rd}, 64'd0);
    check("t6_rst_commit_data", {32'd0, bus.commit_data}, 64'd0);
    check("t6_rst_commit_id", {60'd0, bus.commit_rob_id}, 64'd0);
    check("t6_rst_alloc", {60'd0, bus.alloc_rob_id}, 64'd0);
    tick(); tick();

    check("pending_expected", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement queue for the Tomasulo core.
- Allocates an entry per issued instruction and collects results from the CDB.
- Retires from the head in program order by driving the register file commit port (is_commit/commit_rd/commit_data/commit_rob_id).
- Detects branch mispredicts at the head and broadcasts rollback; also serves ROB-id operand forwarding to the decoder.

Parameters:
- ROB_SZ, 16, number of entries (power of 2)
- ROB_ID_WID, 4, log2(ROB_SZ)
- DATA_WID, 32, data/result width
- REG_ID_WID, 5, architectural register index width
- ADDR_WID, 32, PC width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- rdy  in  1  global ready; state frozen when 0
- issue_valid  in  1  decoder allocates an entry this cycle
- issue_has_rd  in  1  instruction writes rd
- issue_rd  in  REG_ID_WID  destination register
- issue_is_branch  in  1  conditional branch
- issue_pred_jump  in  1  predicted taken
- issue_pc_alt  in  ADDR_WID  PC to restart at if mispredicted
- full  out  1  no free entry (comb)
- alloc_rob_id  out  ROB_ID_WID  id given to the current issue (= tail, comb)
- wb_valid  in  1  CDB result valid
- wb_rob_id  in  ROB_ID_WID  producing entry
- wb_data  in  DATA_WID  result
- wb_jump  in  1  actual branch outcome
- q1_rob_id, q2_rob_id  in  ROB_ID_WID  operand lookup ids
- q1_ready, q2_ready  out  1  result available (comb)
- q1_data, q2_data  out  DATA_WID  forwarded value (comb)
- is_commit  out  1  registered commit strobe
- commit_rd  out  REG_ID_WID  committed destination
- commit_data  out  DATA_WID  committed value
- commit_rob_id  out  ROB_ID_WID  committed entry id
- rollback  out  1  registered flush strobe
- rollback_pc  out  ADDR_WID  restart PC

Behaviour:
- Reset (rst_n=0 at posedge): head=tail=count=0, all entries invalid. is_commit, commit_rd, commit_data, commit_rob_id, rollback and rollback_pc all 0. Reset overrides every other input, including mid-commit.
- rdy=0: no state change; is_commit and rollback are registered 0 (no duplicate strobes).
- full = (count==ROB_SZ). Issue while full is ignored.
- Issue: entry[tail] gets valid=1, ready=0, has_rd, rd, is_branch, pred_jump, pc_alt. Then tail=tail+1 mod ROB_SZ (wraps 15->0).
- Writeback: if entry[wb_rob_id] is valid, it gets ready=1, data=wb_data, jump=wb_jump. Writeback to an invalid entry is ignored.
- Commit check each cycle: entry[head] valid and ready (registered state only; no same-cycle wb bypass into commit). Commit latency is therefore at least 1 cycle after wb.
- On commit:
  - is_commit<=has_rd; commit_rd<=rd; commit_data<=data; commit_rob_id<=head.
  - entry[head] is invalidated; head++ mod ROB_SZ.
  - If has_rd=0, is_commit stays 0 but the entry still retires.
- Mispredict (committing entry is_branch and jump!=pred_jump):
  - rollback<=1, rollback_pc<=pc_alt.
  - All entries invalidated; head=tail=count=0.
  - Any same-cycle issue is discarded.
  - is_commit for the branch itself is still driven. The regfile applies the commit, then clears busy bits.
- Strobe duration: is_commit and rollback are single-cycle pulses, 0 unless set that cycle.
- count update: +1 on accepted issue, -1 on commit. Simultaneous issue and commit leave count unchanged (legal when full: the issue is still rejected because full is combinational on the current count).
- Queries (per port):
  - If wb_valid and wb_rob_id==qN_rob_id and the entry is valid: ready=1, data=wb_data.
  - Else if the entry is valid and ready: ready=1, data=stored data.
  - Else ready=0, data=0.
- Writeback to an entry allocated in the same cycle cannot occur (id not yet visible); no handling is required.

Decomposition:
- Shared constants in const.v: ROB_SZ, ROB_ID_WID, DATA_WID, REG_ID_WID, ADDR_WID.
- Entry fields are held as parallel arrays indexed by ROB id.
- No sub-module; flat RTL of about 200 lines.

Test Plan:
- Reset then issue rd=5; wb id0 data=0x1234 -> next cycle is_commit=1, commit_rd=5, commit_data=0x1234, commit_rob_id=0; count returns to 0.
- Issue ids 0,1; wb id1 before id0 -> no commit until id0 wb. Then commits id0 and id1 on consecutive cycles, in order.
- Issue 16 entries -> full=1; a 17th issue is ignored (alloc_rob_id stays 0). Commit one entry while issuing -> tail wraps; new entry gets id0 after head advances.
- Branch pred_jump=0, pc_alt=0x100; wb_jump=1 at head -> rollback=1, rollback_pc=0x100 for one cycle. Younger entries are flushed; next issue gets alloc_rob_id=0.
- q1_rob_id=3 with wb_valid, wb_rob_id=3, wb_data=0xAA in the same cycle -> q1_ready=1, q1_data=0xAA. An unknown/invalid id gives q1_ready=0.
- rdy=0 while head is ready -> no commit and is_commit=0. rdy=1 -> commit proceeds; rst_n=0 mid-stream clears all outputs next edge.
